// File: rtl/cl2_pl_exu_wbck_if.sv
// Write-back bus bundle: ALU and LSU result handshakes, long-op issue,
// scoreboard queries and the regfile write port.
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif

interface cl2_pl_exu_wbck_if #(
  parameter int unsigned XLEN = `CL2_XLEN,
  parameter int unsigned IDXW = `CL2_REGFILE_WIDTH
);
  // ALU result handshake
  logic            alu_vld_i;
  logic            alu_rdy_o;
  logic [IDXW-1:0] alu_idx_i;
  logic [XLEN-1:0] alu_dat_i;

  // LSU (long-op) result handshake
  logic            lsu_vld_i;
  logic            lsu_rdy_o;
  logic [IDXW-1:0] lsu_idx_i;
  logic [XLEN-1:0] lsu_dat_i;

  // Long-op issue marks its destination pending
  logic            lop_iss_i;
  logic [IDXW-1:0] lop_idx_i;

  // Scoreboard queries
  logic [IDXW-1:0] rs1_idx_i;
  logic [IDXW-1:0] rs2_idx_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;

  // Regfile write port
  logic            wd_wen_o;
  logic [IDXW-1:0] wd_idx_o;
  logic [XLEN-1:0] wd_dat_o;

  // Write-back block side
  modport slave (
    input  alu_vld_i, alu_idx_i, alu_dat_i,
    output alu_rdy_o,
    input  lsu_vld_i, lsu_idx_i, lsu_dat_i,
    output lsu_rdy_o,
    input  lop_iss_i, lop_idx_i,
    input  rs1_idx_i, rs2_idx_i,
    output rs1_busy_o, rs2_busy_o,
    output wd_wen_o, wd_idx_o, wd_dat_o
  );

  // Pipeline / environment side
  modport master (
    output alu_vld_i, alu_idx_i, alu_dat_i,
    input  alu_rdy_o,
    output lsu_vld_i, lsu_idx_i, lsu_dat_i,
    input  lsu_rdy_o,
    output lop_iss_i, lop_idx_i,
    output rs1_idx_i, rs2_idx_i,
    input  rs1_busy_o, rs2_busy_o,
    input  wd_wen_o, wd_idx_o, wd_dat_o
  );
endinterface

// File: rtl/cl2_pl_exu_wbck.sv
// Execution-unit write-back arbiter with a long-op scoreboard.
// LSU results always win the single regfile write port; ALU results stall
// while an LSU result is offered. Writes are registered (one cycle latency).
// The scoreboard tracks registers whose long-op result has not yet landed.
`ifndef CL2_XLEN
`define CL2_XLEN 32
`endif
`ifndef CL2_REGFILE_WIDTH
`define CL2_REGFILE_WIDTH 5
`endif

module cl2_pl_exu_wbck #(
  parameter int unsigned XLEN = `CL2_XLEN,
  parameter int unsigned IDXW = `CL2_REGFILE_WIDTH
) (
  input logic              clk_i,
  input logic              rst_n_i,
  cl2_pl_exu_wbck_if.slave bus
);

  localparam int unsigned NREG = 2 ** IDXW;

  // Handshake / arbitration
  logic alu_xfer;
  logic lsu_xfer;

  // Registered write port
  logic            wd_wen_d, wd_wen_q;
  logic            wd_upd;
  logic [IDXW-1:0] wd_idx_d, wd_idx_q;
  logic [XLEN-1:0] wd_dat_d, wd_dat_q;

  // Scoreboard
  logic [NREG-1:0] pending_d, pending_q;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // LSU is never back-pressured; ALU yields whenever LSU offers a result
  always_comb begin
    bus.lsu_rdy_o = 1'b1;
    bus.alu_rdy_o = ~bus.lsu_vld_i;
    lsu_xfer      = bus.lsu_vld_i;
    alu_xfer      = bus.alu_vld_i & ~bus.lsu_vld_i;
  end

  // Select the winning transfer; x0 targets complete but never write
  always_comb begin
    wd_wen_d = 1'b0;
    wd_upd   = 1'b0;
    wd_idx_d = wd_idx_q;
    wd_dat_d = wd_dat_q;
    if (lsu_xfer) begin
      wd_wen_d = (bus.lsu_idx_i != '0);
      wd_idx_d = bus.lsu_idx_i;
      wd_dat_d = bus.lsu_dat_i;
    end else if (alu_xfer) begin
      wd_wen_d = (bus.alu_idx_i != '0);
      wd_idx_d = bus.alu_idx_i;
      wd_dat_d = bus.alu_dat_i;
    end
    // Index/data only move on a real write so they keep the last written values
    wd_upd = wd_wen_d;
  end

  // Write-port register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_wen_q <= 1'b0;
      wd_idx_q <= '0;
      wd_dat_q <= '0;
    end else begin
      wd_wen_q <= wd_wen_d;
      if (wd_upd) begin
        wd_idx_q <= wd_idx_d;
        wd_dat_q <= wd_dat_d;
      end
    end
  end

  // Scoreboard next state: LSU completion clears, issue sets (issue wins a tie)
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.lop_iss_i && (bus.lop_idx_i != '0)) begin
      set_vec = NREG'(1) << bus.lop_idx_i;
    end
    if (lsu_xfer) begin
      clr_vec = NREG'(1) << bus.lsu_idx_i;
    end
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy covers pending long-ops plus the write still in flight to the regfile
  always_comb begin
    bus.rs1_busy_o = pending_q[bus.rs1_idx_i] |
                     (wd_wen_q && (wd_idx_q == bus.rs1_idx_i));
    bus.rs2_busy_o = pending_q[bus.rs2_idx_i] |
                     (wd_wen_q && (wd_idx_q == bus.rs2_idx_i));
  end

  // Drive the write port from the registers
  always_comb begin
    bus.wd_wen_o = wd_wen_q;
    bus.wd_idx_o = wd_idx_q;
    bus.wd_dat_o = wd_dat_q;
  end

endmodule

// File: tb/tb_cl2_pl_exu_wbck.sv
// Directed, table-driven bench for cl2_pl_exu_wbck.
module tb_cl2_pl_exu_wbck;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IDXW = 5;

  logic clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  cl2_pl_exu_wbck_if #(.XLEN(XLEN), .IDXW(IDXW)) bus ();

  cl2_pl_exu_wbck #(.XLEN(XLEN), .IDXW(IDXW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned alu_vld, alu_idx, alu_dat;
    int unsigned lsu_vld, lsu_idx, lsu_dat;
    int unsigned lop_iss, lop_idx;
    int unsigned rs1, rs2;
    int unsigned e_alu_rdy;
    int unsigned e_wen, e_idx, e_dat, chk_wd;
    int unsigned e_b1, e_b2;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_vld_i = 1'(v.alu_vld);
    bus.alu_idx_i = IDXW'(v.alu_idx);
    bus.alu_dat_i = XLEN'(v.alu_dat);
    bus.lsu_vld_i = 1'(v.lsu_vld);
    bus.lsu_idx_i = IDXW'(v.lsu_idx);
    bus.lsu_dat_i = XLEN'(v.lsu_dat);
    bus.lop_iss_i = 1'(v.lop_iss);
    bus.lop_idx_i = IDXW'(v.lop_idx);
    bus.rs1_idx_i = IDXW'(v.rs1);
    bus.rs2_idx_i = IDXW'(v.rs2);
  endtask

  task automatic idle();
    bus.alu_vld_i = 1'b0;
    bus.lsu_vld_i = 1'b0;
    bus.lop_iss_i = 1'b0;
  endtask

  initial begin
    //          alu v idx dat          lsu v idx dat   lop  rs1 rs2  ardy wen idx dat        chk b1 b2
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  5, 0,  1,  1, 5, 32'hDEADBEEF, 1, 1, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,     0, 0,  5, 0,  1,  0, 5, 32'hDEADBEEF, 1, 0, 0};
    vecs[2]  = '{1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 4, 3,  0,  1, 4, 32'h22,       1, 1, 0};
    vecs[3]  = '{1, 3, 32'h11,       0, 0, 0,     0, 0,  4, 3,  1,  1, 3, 32'h11,       1, 0, 1};
    vecs[4]  = '{0, 0, 0,            0, 0, 0,     1, 7,  7, 7,  1,  0, 3, 32'h11,       1, 1, 1};
    vecs[5]  = '{1, 8, 32'h55,       0, 0, 0,     0, 0,  7, 8,  1,  1, 8, 32'h55,       1, 1, 1};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,     0, 0,  7, 8,  1,  0, 8, 32'h55,       1, 1, 0};
    vecs[7]  = '{0, 0, 0,            1, 7, 32'hAA, 0, 0, 7, 8,  0,  1, 7, 32'hAA,       1, 1, 0};
    vecs[8]  = '{0, 0, 0,            0, 0, 0,     0, 0,  7, 8,  1,  0, 7, 32'hAA,       1, 0, 0};
    vecs[9]  = '{0, 0, 0,            1, 9, 32'h99, 1, 9, 9, 7,  0,  1, 9, 32'h99,       1, 1, 0};
    vecs[10] = '{0, 0, 0,            0, 0, 0,     0, 0,  9, 0,  1,  0, 9, 32'h99,       1, 1, 0};
    vecs[11] = '{1, 0, 32'h1234,     0, 0, 0,     0, 0,  9, 0,  1,  0, 0, 0,            0, 1, 0};
    vecs[12] = '{0, 0, 0,            0, 0, 0,     1, 0,  0, 0,  1,  0, 0, 0,            0, 0, 0};
    vecs[13] = '{0, 0, 0,            1, 9, 32'h77, 0, 0, 9, 0,  0,  1, 9, 32'h77,       1, 1, 0};
    vecs[14] = '{0, 0, 0,            0, 0, 0,     0, 0,  9, 0,  1,  0, 9, 32'h77,       1, 0, 0};

    // Reset state
    rst_n = 1'b0;
    bus.alu_idx_i = '0; bus.alu_dat_i = '0;
    bus.lsu_idx_i = '0; bus.lsu_dat_i = '0;
    bus.lop_idx_i = '0;
    bus.rs1_idx_i = 5'd3; bus.rs2_idx_i = 5'd0;
    idle();
    #1;
    check("rst_wen", 64'(bus.wd_wen_o), 64'd0);
    check("rst_idx", 64'(bus.wd_idx_o), 64'd0);
    check("rst_dat", 64'(bus.wd_dat_o), 64'd0);
    check("rst_busy1", 64'(bus.rs1_busy_o), 64'd0);
    check("rst_lsu_rdy", 64'(bus.lsu_rdy_o), 64'd1);
    check("rst_alu_rdy", 64'(bus.alu_rdy_o), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_wen", 64'(bus.wd_wen_o), 64'd0);

    // Table-driven vectors: outputs checked #1 after the edge that takes them
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_alu_rdy", i), 64'(bus.alu_rdy_o), 64'(vecs[i].e_alu_rdy));
      check($sformatf("v%0d_lsu_rdy", i), 64'(bus.lsu_rdy_o), 64'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_wen", i), 64'(bus.wd_wen_o), 64'(vecs[i].e_wen));
      if (vecs[i].chk_wd != 0) begin
        check($sformatf("v%0d_idx", i), 64'(bus.wd_idx_o), 64'(vecs[i].e_idx));
        check($sformatf("v%0d_dat", i), 64'(bus.wd_dat_o), 64'(vecs[i].e_dat));
      end
      check($sformatf("v%0d_busy1", i), 64'(bus.rs1_busy_o), 64'(vecs[i].e_b1));
      check($sformatf("v%0d_busy2", i), 64'(bus.rs2_busy_o), 64'(vecs[i].e_b2));
    end

    // Reset right after an LSU accept with pending bits set
    @(negedge clk);
    idle();
    bus.lop_iss_i = 1'b1; bus.lop_idx_i = 5'd10;
    @(negedge clk);
    bus.lop_idx_i = 5'd11;
    @(negedge clk);
    bus.lop_iss_i = 1'b0;
    bus.lsu_vld_i = 1'b1; bus.lsu_idx_i = 5'd10; bus.lsu_dat_i = 32'hCC;
    bus.rs1_idx_i = 5'd11; bus.rs2_idx_i = 5'd10;
    @(posedge clk); #1;
    check("pre_rst_wen", 64'(bus.wd_wen_o), 64'd1);
    check("pre_rst_dat", 64'(bus.wd_dat_o), 64'hCC);
    check("pre_rst_busy1", 64'(bus.rs1_busy_o), 64'd1);
    check("pre_rst_busy2", 64'(bus.rs2_busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 64'(bus.wd_wen_o), 64'd0);
    check("mid_rst_idx", 64'(bus.wd_idx_o), 64'd0);
    check("mid_rst_dat", 64'(bus.wd_dat_o), 64'd0);
    check("mid_rst_busy1", 64'(bus.rs1_busy_o), 64'd0);
    check("mid_rst_busy2", 64'(bus.rs2_busy_o), 64'd0);
    check("mid_rst_alu_rdy_lsu", 64'(bus.alu_rdy_o), 64'd0);
    check("mid_rst_lsu_rdy", 64'(bus.lsu_rdy_o), 64'd1);
    bus.lsu_vld_i = 1'b0;
    #1;
    check("mid_rst_alu_rdy_idle", 64'(bus.alu_rdy_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("rel%0d_wen", k), 64'(bus.wd_wen_o), 64'd0);
      check($sformatf("rel%0d_busy1", k), 64'(bus.rs1_busy_o), 64'd0);
      check($sformatf("rel%0d_busy2", k), 64'(bus.rs2_busy_o), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cl2_pl_exu_wbck.md
CL2_PL_EXU_WBCK -- requirements
Module: cl2_pl_exu_wbck

Interface
REQ-001 The block SHALL have parameter XLEN, default `CL2_XLEN, meaning the data width.
REQ-002 The block SHALL have parameter IDXW, default `CL2_REGFILE_WIDTH, meaning the register index width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port alu_vld_i / alu_rdy_o, input / output, 1 bit each: ALU result handshake.
REQ-006 The block SHALL have port alu_idx_i / alu_dat_i, input, IDXW / XLEN: ALU destination index and data.
REQ-007 The block SHALL have port lsu_vld_i / lsu_rdy_o, input / output, 1 bit each: LSU (long-op) result handshake.
REQ-008 The block SHALL have port lsu_idx_i / lsu_dat_i, input, IDXW / XLEN: LSU destination index and data.
REQ-009 The block SHALL have port lop_iss_i / lop_idx_i, input, 1 / IDXW: long-op issued, destination marked pending.
REQ-010 The block SHALL have port rs1_idx_i / rs2_idx_i, input, IDXW each: scoreboard query indices.
REQ-011 The block SHALL have port rs1_busy_o / rs2_busy_o, output, 1 bit each: the queried register is not yet readable from the regfile.
REQ-012 The block SHALL have port wd_wen_o / wd_idx_o / wd_dat_o, output, 1 / IDXW / XLEN: regfile write port.

Function
REQ-013 A transfer SHALL occur on a port when vld and rdy are both high at a rising clk_i edge.
REQ-014 lsu_rdy_o SHALL be constant 1; LSU has absolute priority.
REQ-015 alu_rdy_o SHALL equal ~lsu_vld_i, combinationally.
REQ-016 The winning transfer SHALL be registered onto wd_*_o with exactly one cycle of latency: it is accepted at edge N and wd_wen_o is high for the cycle after edge N.
REQ-017 wd_wen_o SHALL be 0 in any cycle after an edge with no transfer; wd_idx_o/wd_dat_o SHALL hold their last values.
REQ-018 A transfer with idx 0 SHALL complete its handshake but SHALL produce wd_wen_o=0.
REQ-019 The scoreboard SHALL be a 2^IDXW-bit pending vector; bit 0 SHALL be constant 0.
REQ-020 lop_iss_i with lop_idx_i!=0 SHALL set pending[lop_idx_i] at the next edge; if the bit is already set it SHALL stay set.
REQ-021 An LSU transfer SHALL clear pending[lsu_idx_i] at the same edge.
REQ-022 If an issue and an LSU completion target the same idx at the same edge, the bit SHALL end set (issue wins).
REQ-023 rsN_busy_o SHALL equal pending[rsN_idx_i] | (wd_wen_o & wd_idx_o==rsN_idx_i), combinationally; it SHALL be 0 for idx 0.
REQ-024 An ALU transfer SHALL NOT modify the scoreboard.
REQ-025 rs1 and rs2 queries SHALL be independent and may address the same index.

Reset
REQ-026 While rst_n_i=0: wd_wen_o=0, wd_idx_o=0, wd_dat_o=0, and pending=all zero; these take effect asynchronously.
REQ-027 Reset mid-operation SHALL discard any in-flight write and all pending bits; no write SHALL be emitted after release for a pre-reset transfer.
REQ-028 During reset, rsN_busy_o SHALL read 0.
REQ-029 During reset, alu_rdy_o and lsu_rdy_o SHALL still follow REQ-014 and REQ-015.

Verification
REQ-030 Single ALU write: alu_vld=1, idx=5, dat=0xDEADBEEF -> next cycle wd_wen=1, idx=5, dat=0xDEADBEEF; the following cycle wd_wen=0.
REQ-031 Collision: ALU (idx 3, 0x11) and LSU (idx 4, 0x22) valid together -> alu_rdy=0; write idx4=0x22 is emitted; the ALU transfer follows one cycle later, giving idx3=0x11.
REQ-032 Scoreboard: issue idx 7 -> rs1_busy(7)=1 until the LSU completes idx 7; it stays 1 during the wd_wen cycle and reads 0 the cycle after.
REQ-033 Same-edge issue and completion of idx 9 -> pending[9] remains 1.
REQ-034 x0 cases: ALU to idx 0 -> handshake completes, wd_wen stays 0; issue to idx 0 -> busy(0)=0.
REQ-035 Reset asserted in the cycle after an LSU accept with pending bits set -> wd_wen=0 immediately; all busy outputs read 0 after release.
